// File: rtl/t01_pkg.sv
// Shared types and constants for the t01 program-counter stage.
package t01_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HALT  = 2'd1,
    FAULT = 2'd2
  } pc_state_t;

  // Branch condition encodings carried in funct3
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h3300_0000;

endpackage

// File: rtl/t01_branch_cond.sv
// Branch condition evaluation from ALU flags (signed/equality) and raw operands (unsigned).
module t01_branch_cond
  import t01_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic        zero,
  input  logic        negative,
  input  logic        overflow,
  input  logic [31:0] rs1data,
  input  logic [31:0] rs2data,
  output logic        cond
);

  logic lt;
  logic ltu;

  assign lt  = negative ^ overflow;
  assign ltu = rs1data < rs2data;

  // Select the condition for the encoded comparison; reserved encodings never branch
  always_comb begin
    cond = 1'b0;
    case (funct3)
      F3_BEQ:  cond = zero;
      F3_BNE:  cond = ~zero;
      F3_BLT:  cond = lt;
      F3_BGE:  cond = ~lt;
      F3_BLTU: cond = ltu;
      F3_BGEU: cond = ~ltu;
      default: cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/t01_pc_unit.sv
// Program counter, branch/jump resolution and RUN/HALT/FAULT control.
module t01_pc_unit
  import t01_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        nRst,
  input  logic        Advance,
  input  logic        Branch,
  input  logic        Jal,
  input  logic        Jalr,
  input  logic        Halt,
  input  logic        Clear,
  input  logic [2:0]  Funct3,
  input  logic        Zero,
  input  logic        Negative,
  input  logic        Overflow,
  input  logic [31:0] AluResult,
  input  logic [31:0] Rs1Data,
  input  logic [31:0] Rs2Data,
  input  logic [31:0] Imm,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic        Taken,
  output logic        Flush,
  output logic        Fault,
  output logic        Halted
);

  pc_state_t   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        flush_q, flush_d;
  logic [31:0] target;
  logic        cond;
  logic        misaligned;

  t01_branch_cond u_cond (
    .funct3   (Funct3),
    .zero     (Zero),
    .negative (Negative),
    .overflow (Overflow),
    .rs1data  (Rs1Data),
    .rs2data  (Rs2Data),
    .cond     (cond)
  );

  assign PCPlus4 = pc_q + 32'd4;

  // Resolve taken and the next fetch address; JALR outranks JAL, both outrank Branch
  always_comb begin
    Taken = Jal | Jalr | (Branch & cond);
    if (Jalr) begin
      target = {AluResult[31:1], 1'b0};
    end else if (Taken) begin
      target = pc_q + Imm;
    end else begin
      target = PCPlus4;
    end
    misaligned = Taken & (target[1:0] != 2'b00);
  end

  // State, PC and flush registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!nRst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      flush_q <= flush_d;
    end
  end

  // Next-state logic: Clear restarts from any state, Halt beats a taken redirect
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    flush_d = 1'b0;
    case (state_q)
      RUN: begin
        if (Clear) begin
          pc_d = RESET_PC;
        end else if (Advance) begin
          if (Halt) begin
            state_d = HALT;
          end else if (misaligned) begin
            state_d = FAULT;
          end else begin
            pc_d    = target;
            flush_d = Taken;
          end
        end
      end
      HALT, FAULT: begin
        if (Clear) begin
          state_d = RUN;
          pc_d    = RESET_PC;
        end
      end
      default: begin
        state_d = RUN;
        pc_d    = RESET_PC;
      end
    endcase
  end

  assign PC     = pc_q;
  assign Flush  = flush_q;
  assign Fault  = (state_q == FAULT);
  assign Halted = (state_q == HALT);

endmodule

// File: tb/tb_t01_pc_unit.sv
// Directed and randomized checks of t01_pc_unit against a behavioural model.
module tb_t01_pc_unit;

  localparam logic [31:0] RST_PC = 32'h3300_0000;

  logic        clk = 1'b0;
  logic        nRst, Advance, Branch, Jal, Jalr, Halt, Clear;
  logic [2:0]  Funct3;
  logic        Zero, Negative, Overflow;
  logic [31:0] AluResult, Rs1Data, Rs2Data, Imm;
  logic [31:0] PC, PCPlus4;
  logic        Taken, Flush, Fault, Halted;

  logic [31:0] d1, d2, diff;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Behavioural model state
  logic [31:0] m_pc;
  bit          m_valid = 0, m_flush, m_halt, m_fault;

  always #5 clk = ~clk;

  // ALU-style flags for Data1 - Data2
  assign diff     = d1 - d2;
  assign Zero     = (diff == 32'd0);
  assign Negative = diff[31];
  assign Overflow = (d1[31] != d2[31]) && (diff[31] != d1[31]);
  assign Rs1Data  = d1;
  assign Rs2Data  = d2;

  t01_pc_unit #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .nRst(nRst), .Advance(Advance), .Branch(Branch), .Jal(Jal),
    .Jalr(Jalr), .Halt(Halt), .Clear(Clear), .Funct3(Funct3), .Zero(Zero),
    .Negative(Negative), .Overflow(Overflow), .AluResult(AluResult),
    .Rs1Data(Rs1Data), .Rs2Data(Rs2Data), .Imm(Imm), .PC(PC),
    .PCPlus4(PCPlus4), .Taken(Taken), .Flush(Flush), .Fault(Fault),
    .Halted(Halted)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_cond(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return $signed(a) <  $signed(b);
      3'b101:  return $signed(a) >= $signed(b);
      3'b110:  return a <  b;
      3'b111:  return a >= b;
      default: return 0;
    endcase
  endfunction

  function automatic bit m_taken();
    return Jal || Jalr || (Branch && m_cond(Funct3, d1, d2));
  endfunction

  function automatic logic [31:0] m_target();
    if (Jalr)           return AluResult & 32'hFFFF_FFFE;
    else if (m_taken()) return m_pc + Imm;
    else                return m_pc + 32'd4;
  endfunction

  task automatic idle();
    nRst = 1; Advance = 0; Branch = 0; Jal = 0; Jalr = 0; Halt = 0; Clear = 0;
    Funct3 = 3'b000; d1 = 0; d2 = 0; AluResult = 0; Imm = 0;
  endtask

  // One clock: combinational checks before the edge, model step and registered checks after
  task automatic cycle();
    bit          tk;
    logic [31:0] tg;
    #2;
    tk = m_taken();
    tg = m_target();
    if (m_valid) begin
      chk("taken", {31'd0, Taken}, {31'd0, tk});
      chk("pcplus4", PCPlus4, m_pc + 32'd4);
    end
    @(posedge clk);
    if (!nRst) begin
      m_valid = 1; m_pc = RST_PC; m_flush = 0; m_halt = 0; m_fault = 0;
    end else if (m_valid) begin
      m_flush = 0;
      if (m_halt || m_fault) begin
        if (Clear) begin m_halt = 0; m_fault = 0; m_pc = RST_PC; end
      end else if (Clear) begin
        m_pc = RST_PC;
      end else if (Advance) begin
        if (Halt)                    m_halt = 1;
        else if (tk && tg[1:0] != 0) m_fault = 1;
        else begin m_pc = tg; m_flush = tk; end
      end
    end
    #1;
    if (m_valid) begin
      chk("pc", PC, m_pc);
      chk("flush", {31'd0, Flush}, {31'd0, m_flush});
      chk("fault", {31'd0, Fault}, {31'd0, m_fault});
      chk("halted", {31'd0, Halted}, {31'd0, m_halt});
    end
  endtask

  initial begin
    idle();
    nRst = 0;
    cycle();
    cycle();

    // Sequential fetch
    idle(); Advance = 1;
    repeat (4) cycle();
    chk("seq_pc", PC, 32'h3300_0010);

    // BLT taken backwards
    idle(); Advance = 1; Branch = 1; Funct3 = 3'b100; d1 = 32'hFFFF_FFFF; d2 = 32'd1;
    Imm = 32'hFFFF_FFF0;
    cycle();
    chk("blt_pc", PC, 32'h3300_0000);
    chk("blt_flush", {31'd0, Flush}, 32'd1);
    idle();
    cycle();
    chk("flush_pulse", {31'd0, Flush}, 32'd0);

    // BLTU not taken for the same operands
    idle(); Advance = 1; Branch = 1; Funct3 = 3'b110; d1 = 32'hFFFF_FFFF; d2 = 32'd1;
    Imm = 32'hFFFF_FFF0;
    cycle();
    chk("bltu_pc", PC, 32'h3300_0004);

    // JALR clears bit 0, then a misaligned JALR faults
    idle(); Advance = 1; Jalr = 1; AluResult = 32'h3300_0101;
    cycle();
    chk("jalr_pc", PC, 32'h3300_0100);
    AluResult = 32'h3300_0102;
    cycle();
    chk("jalr_fault", {31'd0, Fault}, 32'd1);
    idle(); Advance = 1;
    repeat (2) cycle();
    idle(); Clear = 1;
    cycle();
    chk("clear_pc", PC, RST_PC);

    // Halt wins over JAL
    idle(); Advance = 1; Halt = 1; Jal = 1; Imm = 32'd64;
    cycle();
    idle(); Advance = 1; Jal = 1; Imm = 32'd64;
    repeat (2) cycle();
    chk("halt_pc", PC, RST_PC);
    idle(); Clear = 1;
    cycle();

    // Wrap at the top of the address space, then hold with Advance low
    idle(); Advance = 1; Jal = 1; Imm = 32'hCCFF_FFFC;
    cycle();
    chk("jal_top", PC, 32'hFFFF_FFFC);
    idle(); Advance = 1;
    cycle();
    chk("wrap_pc", PC, 32'h0000_0000);
    idle(); Advance = 1; Jal = 1; Imm = 32'd8;
    cycle();
    idle(); Jal = 1; Imm = 32'd8; Branch = 1;
    cycle();
    chk("hold_pc", PC, 32'h0000_0008);

    // Reset beats Clear and Advance while faulted
    idle(); Advance = 1; Jalr = 1; AluResult = 32'h0000_0102;
    cycle();
    idle(); nRst = 0; Clear = 1; Advance = 1; Jal = 1; Imm = 32'd4;
    cycle();
    chk("rst_fault", {31'd0, Fault}, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      idle();
      nRst    = ($urandom_range(0, 31) != 0);
      Clear   = ($urandom_range(0, 15) == 0);
      Halt    = ($urandom_range(0, 15) == 0);
      Advance = ($urandom_range(0, 3) != 0);
      Branch  = $urandom_range(0, 1);
      Jal     = ($urandom_range(0, 5) == 0);
      Jalr    = ($urandom_range(0, 5) == 0);
      Funct3  = 3'($urandom_range(0, 7));
      d1      = $urandom();
      d2      = ($urandom_range(0, 3) == 0) ? d1 : $urandom();
      if ($urandom_range(0, 1) != 0) begin
        d1 = {d2[31], 31'($urandom_range(0, 15))};
      end
      Imm       = 32'($urandom_range(0, 255)) * 4 - 32'd512;
      if ($urandom_range(0, 7) == 0) Imm = Imm + 32'($urandom_range(1, 3));
      AluResult = RST_PC + 32'($urandom_range(0, 1023));
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
